// File: rtl/fabric_arbiter_pkg.sv
// rtl/fabric_arbiter_pkg.sv - OCP codes, bus widths and arbiter FSM encodings shared by fabric_arbiter
`ifndef OCP_CONST_VH
`define OCP_CONST_VH
`define OCP_CMD_IDLE  3'b000
`define OCP_CMD_WR    3'b001
`define OCP_CMD_RD    3'b010
`define OCP_RESP_NULL 2'b00
`define OCP_RESP_DVA  2'b01
`define OCP_RESP_FAIL 2'b10
`define OCP_RESP_ERR  2'b11
`endif

`ifndef COMMON_VH
`define COMMON_VH
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define BEN_WIDTH  4
`define FABRIC_ARB_IDLE 3'b001
`define FABRIC_ARB_CMD  3'b010
`define FABRIC_ARB_RESP 3'b100
`endif

package fabric_arbiter_pkg;
  localparam int ADDR_WIDTH = `ADDR_WIDTH;
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int BEN_WIDTH  = `BEN_WIDTH;

  localparam logic [2:0] OCP_CMD_IDLE  = `OCP_CMD_IDLE;
  localparam logic [1:0] OCP_RESP_NULL = `OCP_RESP_NULL;
  localparam logic [1:0] OCP_RESP_ERR  = `OCP_RESP_ERR;

  typedef enum logic [2:0] {
    ARB_IDLE = `FABRIC_ARB_IDLE,
    ARB_CMD  = `FABRIC_ARB_CMD,
    ARB_RESP = `FABRIC_ARB_RESP
  } arb_state_e;
endpackage

// File: rtl/fabric_arbiter_if.sv
// rtl/fabric_arbiter_if.sv - OCP master-side and slave-side signal bundle around fabric_arbiter
interface fabric_arbiter_if
  import fabric_arbiter_pkg::*;
#(
  parameter int NMASTERS = 2
) ();
  logic [NMASTERS*ADDR_WIDTH-1:0] i_M_MAddr;
  logic [NMASTERS*3-1:0]          i_M_MCmd;
  logic [NMASTERS*DATA_WIDTH-1:0] i_M_MData;
  logic [NMASTERS*BEN_WIDTH-1:0]  i_M_MByteEn;
  logic [NMASTERS-1:0]            o_M_SCmdAccept;
  logic [NMASTERS*DATA_WIDTH-1:0] o_M_SData;
  logic [NMASTERS*2-1:0]          o_M_SResp;
  logic [ADDR_WIDTH-1:0]          o_S_MAddr;
  logic [2:0]                     o_S_MCmd;
  logic [DATA_WIDTH-1:0]          o_S_MData;
  logic [BEN_WIDTH-1:0]           o_S_MByteEn;
  logic                           i_S_SCmdAccept;
  logic [DATA_WIDTH-1:0]          i_S_SData;
  logic [1:0]                     i_S_SResp;

  // slave: the arbiter's view; master: the surrounding masters plus shared slave
  modport slave (
    input  i_M_MAddr, i_M_MCmd, i_M_MData, i_M_MByteEn, i_S_SCmdAccept, i_S_SData, i_S_SResp,
    output o_M_SCmdAccept, o_M_SData, o_M_SResp, o_S_MAddr, o_S_MCmd, o_S_MData, o_S_MByteEn
  );
  modport master (
    output i_M_MAddr, i_M_MCmd, i_M_MData, i_M_MByteEn, i_S_SCmdAccept, i_S_SData, i_S_SResp,
    input  o_M_SCmdAccept, o_M_SData, o_M_SResp, o_S_MAddr, o_S_MCmd, o_S_MData, o_S_MByteEn
  );
endinterface

// File: rtl/fabric_arb_rrpick.sv
// rtl/fabric_arb_rrpick.sv - combinational round-robin picker, searching last+1 .. last modulo N
module fabric_arb_rrpick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] idx
);
  // Walk from the farthest candidate inward so the nearest requester after last wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        valid = 1'b1;
        idx   = W'((int'(last) + i) % N);
      end
    end
  end
endmodule

// File: rtl/fabric_arbiter.sv
// rtl/fabric_arbiter.sv - round-robin OCP arbiter, one transaction outstanding; FABRIC_ARB_TIMEOUT_EN adds a response timeout
module fabric_arbiter
  import fabric_arbiter_pkg::*;
#(
  parameter int NMASTERS = 2,
  parameter int TIMEOUT  = 255
) (
  input logic              clk,
  input logic              nrst,
  fabric_arbiter_if.slave  bus
);
  localparam int W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

  if (NMASTERS < 2 || NMASTERS > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("fabric_arbiter: parameter out of range");
  end

  arb_state_e          state, next;
  logic [W-1:0]        last, gnt, pick_idx;
  logic                pick_valid;
  logic [NMASTERS-1:0] req;
  logic                timeout_hit;

  logic [NMASTERS-1:0]            m_acc;
  logic [NMASTERS*DATA_WIDTH-1:0] m_sdata;
  logic [NMASTERS*2-1:0]          m_sresp;
  logic [ADDR_WIDTH-1:0]          s_addr;
  logic [2:0]                     s_cmd;
  logic [DATA_WIDTH-1:0]          s_data;
  logic [BEN_WIDTH-1:0]           s_ben;

  always_comb begin
    req = '0;
    for (int k = 0; k < NMASTERS; k++)
      req[k] = (bus.i_M_MCmd[k*3 +: 3] != OCP_CMD_IDLE);
  end

  fabric_arb_rrpick #(.N(NMASTERS), .W(W)) u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ARB_IDLE;
      last  <= '0;
      gnt   <= '0;
    end else begin
      state <= next;
      if (state == ARB_IDLE && pick_valid) begin
        gnt  <= pick_idx;
        last <= pick_idx;
      end
    end
  end

`ifdef FABRIC_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Held at zero outside RESP, so it reads 0 on the first RESP cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                 to_cnt <= '0;
    else if (state != ARB_RESP) to_cnt <= '0;
    else                       to_cnt <= to_cnt + 8'd1;
  end

  assign timeout_hit = (to_cnt == 8'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    next    = state;
    m_acc   = '0;
    m_sdata = '0;
    m_sresp = '0;
    s_addr  = '0;
    s_cmd   = OCP_CMD_IDLE;
    s_data  = '0;
    s_ben   = '0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) next = ARB_CMD;
      end
      ARB_CMD: begin
        s_addr     = bus.i_M_MAddr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
        s_cmd      = bus.i_M_MCmd[gnt*3 +: 3];
        s_data     = bus.i_M_MData[gnt*DATA_WIDTH +: DATA_WIDTH];
        s_ben      = bus.i_M_MByteEn[gnt*BEN_WIDTH +: BEN_WIDTH];
        m_acc[gnt] = bus.i_S_SCmdAccept;
        if (bus.i_S_SCmdAccept) next = ARB_RESP;
      end
      ARB_RESP: begin
        m_sdata[gnt*DATA_WIDTH +: DATA_WIDTH] = bus.i_S_SData;
        m_sresp[gnt*2 +: 2]                   = bus.i_S_SResp;
        // A real response on the timeout cycle takes precedence over the error.
        if (bus.i_S_SResp != OCP_RESP_NULL) begin
          next = ARB_IDLE;
        end else if (timeout_hit) begin
          m_sresp[gnt*2 +: 2] = OCP_RESP_ERR;
          next                = ARB_IDLE;
        end
      end
      default: next = ARB_IDLE;
    endcase
  end

  assign bus.o_M_SCmdAccept = m_acc;
  assign bus.o_M_SData      = m_sdata;
  assign bus.o_M_SResp      = m_sresp;
  assign bus.o_S_MAddr      = s_addr;
  assign bus.o_S_MCmd       = s_cmd;
  assign bus.o_S_MData      = s_data;
  assign bus.o_S_MByteEn    = s_ben;
endmodule
